writeback_sequencer: RTL
========================

# writeback_sequencer

Sequences the single register-file/predicate-status write port of the pipelined NAND CPU. It accepts retiring instructions from the action-pass stage, holds each in program order, and waits for load data from memory where needed. It then drives the writeback interface with exactly one in-order write per cycle. It sits between the action-pass stage and the register file, and backpressures the pipeline when its order queue is full.

## Interface
Parameters:
- DEPTH, 4: order-queue entries (power of two, ≥2).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- act_valid  in  1  action-pass instruction present
- act_mem_access  in  1  instruction accesses memory
- act_reg_write  in  1  instruction writes a register
- act_reg_addr  in  4  destination register
- act_reg_data  in  16  execute result (ignored for loads)
- act_ps_write  in  1  instruction writes predicate/status bit
- act_ps_data  in  1  predicate/status value
- act_stall  out  1  queue cannot accept; upstream holds act_*
- mem_resp_valid  in  1  load data returning (in request order, never stalled)
- mem_resp_data  in  16  load data
- wb_valid, wb_reg_write, wb_ps_write, wb_ps_data  out  1 each  writeback fields
- wb_reg_addr  out  4; wb_reg_data  out  16  writeback fields
- loads_pending  out  $clog2(DEPTH)+1  queued loads not yet filled
- resp_error  out  1  sticky: response arrived with no unfilled load queued

## Operation
- Entry = {is_load, filled, reg_write, reg_addr, reg_data, ps_write, ps_data}. Circular queue with head/tail pointers and count (0..DEPTH).
- Accept: act_valid && !act_stall. Only instructions with act_reg_write || act_ps_write are enqueued; all others (stores, branches without ps) are accepted and dropped.
- is_load = act_mem_access && act_reg_write. Loads enqueue with filled=0; all other entries enqueue with filled=1 and data captured.
- act_stall = (count == DEPTH). It is combinational from registered count. A same-cycle pop does not clear it.
- Fill: on mem_resp_valid, the oldest queued entry (searching from head) with is_load && !filled latches mem_resp_data and sets filled=1. Entries enqueued in the same cycle are not candidates. If no candidate exists, the response is dropped and resp_error sets.
- Retire: when count>0 and the head has filled=1, the head pops, its fields are registered onto wb_*, and wb_valid=1 for one cycle. Otherwise wb_valid=0 and the other wb_* fields hold their previous values.
- Writebacks occur strictly in program order. A later non-load never overtakes an earlier unfilled load, including writes to other registers.
- loads_pending = count of is_load && !filled entries, registered.
- Reset: queue empty. wb_* = 0, act_stall = 0, loads_pending = 0, resp_error = 0. In-flight entries are discarded. resp_error clears only on rst.

## Timing
- Non-load retire latency: enqueue at edge N, wb_valid high in cycle N+1 when it is head, else one cycle after the head becomes filled.
- Load: response at edge M fills the entry. Writeback is in cycle M+1 at the earliest, and later if older entries are blocked.
- Throughput: one enqueue and one retire per cycle. A simultaneous enqueue and pop leaves count unchanged.
- Full: count==DEPTH asserts act_stall. A pop that cycle brings count to DEPTH-1, and act_stall drops the following cycle.
- Empty: no retire, wb_valid=0. An enqueue into an empty queue retires the next cycle.
- Pointers wrap modulo DEPTH. Count is kept separately, so full and empty are unambiguous.
- A fill and a retire in the same cycle target different entries. A head filled at edge M retires at edge M+1 and is never bypassed combinationally.

## Structure
- Entry struct typedef (wb_entry_t) and the 4-bit register-address width constant go in the shared nand_cpu.svh definitions, alongside the writeback/action-pass interface field widths.
- The oldest-unfilled-load priority search is a natural sub-module: wb_fill_select (DEPTH-wide valid mask plus head pointer in, one-hot select and found out).
- Everything else is in writeback_sequencer.

## Test plan
- ALU stream: 3 non-load ops r1=0x0001, r2=0x0002, r3=0x0003 on consecutive cycles -> wb_valid on 3 consecutive cycles, same order and data, one cycle after each enqueue.
- Load blocking: load r4, then ALU r5=0x00AA; response 0xBEEF after 5 cycles -> r4=0xBEEF writes first, r5=0x00AA the next cycle; loads_pending goes 1 then 0.
- Full/backpressure (DEPTH=4): 4 loads, no responses -> act_stall=1, a 5th act held. Response 0x1234 -> head retires, act_stall drops, 5th accepted.
- Spurious response: mem_resp_valid with an empty queue -> no wb_valid, resp_error=1 and sticky until rst.
- Non-writing drop: store (mem_access=1, reg_write=0, ps_write=0) -> accepted, no writeback, count unchanged. ps-only op ps_data=1 -> wb_ps_write=1, wb_reg_write=0.
- Reset mid-operation: 2 unfilled loads queued, assert rst async -> all outputs 0 immediately. After release, ALU r7=0x0007 retires normally the next cycle.

Source files
------------

// File: rtl/writeback_sequencer_pkg.sv
// Shared writeback definitions for the NAND CPU.
// Holds the order-queue entry layout and writeback field widths.
package writeback_sequencer_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;

    typedef struct packed {
        logic                  is_load;
        logic                  filled;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     reg_data;
        logic                  ps_write;
        logic                  ps_data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_sequencer_fill_select.sv
// Oldest-unfilled-load finder: scans the candidate mask starting at head.
// Produces a one-hot select of the first candidate and a found flag.
module wb_fill_select #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_mask,
    input  logic [PW-1:0]    i_head,
    output logic [DEPTH-1:0] o_sel,
    output logic             o_found
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_sel   = '0;
        o_found = 1'b0;
        w_idx   = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            if (!o_found && i_mask[w_idx]) begin
                o_sel[w_idx] = 1'b1;
                o_found      = 1'b1;
            end
            w_idx = w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/writeback_sequencer.sv
// In-order writeback sequencer: queues retiring instructions, fills loads
// from memory responses, and drains one write per cycle to the register file.
module writeback_sequencer
    import writeback_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  act_valid,
    input  logic                  act_mem_access,
    input  logic                  act_reg_write,
    input  logic [REG_ADDR_W-1:0] act_reg_addr,
    input  logic [DATA_W-1:0]     act_reg_data,
    input  logic                  act_ps_write,
    input  logic                  act_ps_data,
    output logic                  act_stall,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_reg_addr,
    output logic [DATA_W-1:0]     wb_reg_data,
    output logic                  wb_ps_write,
    output logic                  wb_ps_data,
    output logic [CW-1:0]         loads_pending,
    output logic                  resp_error
);

    wb_entry_t      r_q [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    logic           w_accept;
    logic           w_enq;
    logic           w_enq_load;
    logic           w_pop;
    logic           w_fill;
    logic [DEPTH-1:0] w_mask;
    logic [DEPTH-1:0] w_sel;
    logic             w_found;
    logic [PW-1:0]    w_off [DEPTH];
    wb_entry_t        w_new;

    assign act_stall  = (r_count == CW'(DEPTH));
    assign w_accept   = act_valid && !act_stall;
    assign w_enq      = w_accept && (act_reg_write || act_ps_write);
    assign w_enq_load = w_enq && act_mem_access && act_reg_write;
    assign w_pop      = (r_count != '0) && r_q[r_head].filled;
    assign w_fill     = mem_resp_valid && w_found;

    always_comb begin
        w_new           = '0;
        w_new.is_load   = act_mem_access && act_reg_write;
        w_new.filled    = !(act_mem_access && act_reg_write);
        w_new.reg_write = act_reg_write;
        w_new.reg_addr  = act_reg_addr;
        w_new.reg_data  = act_reg_data;
        w_new.ps_write  = act_ps_write;
        w_new.ps_data   = act_ps_data;
    end

    // Only occupied slots (offset from head below count) are fill candidates.
    for (genvar g = 0; g < DEPTH; g++) begin : g_mask
        assign w_off[g]  = PW'(g) - r_head;
        assign w_mask[g] = ({1'b0, w_off[g]} < r_count)
                           && r_q[g].is_load && !r_q[g].filled;
    end

    wb_fill_select #(.DEPTH(DEPTH)) u_fill_select (
        .i_mask  (w_mask),
        .i_head  (r_head),
        .o_sel   (w_sel),
        .o_found (w_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_reg_addr   <= '0;
            wb_reg_data   <= '0;
            wb_ps_write   <= 1'b0;
            wb_ps_data    <= 1'b0;
            loads_pending <= '0;
            resp_error    <= 1'b0;
        end else begin
            if (w_enq) begin
                r_q[r_tail] <= w_new;
                r_tail      <= r_tail + 1'b1;
            end
            if (w_fill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_sel[i]) begin
                        r_q[i].reg_data <= mem_resp_data;
                        r_q[i].filled   <= 1'b1;
                    end
                end
            end
            if (mem_resp_valid && !w_found) resp_error <= 1'b1;
            if (w_pop) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= r_q[r_head].reg_write;
                wb_reg_addr  <= r_q[r_head].reg_addr;
                wb_reg_data  <= r_q[r_head].reg_data;
                wb_ps_write  <= r_q[r_head].ps_write;
                wb_ps_data   <= r_q[r_head].ps_data;
                r_head       <= r_head + 1'b1;
            end else begin
                wb_valid     <= 1'b0;
            end
            r_count       <= r_count + CW'(w_enq) - CW'(w_pop);
            loads_pending <= loads_pending + CW'(w_enq_load) - CW'(w_fill);
        end
    end

endmodule
